// File: rtl/uart_frame_parser.sv
// Byte-level frame decoder: HEADER, CMD, LEN, payload, CSUM. Payload lands in an internal buffer.
// Optional inter-byte timeout is built only when FRAME_TIMEOUT_EN is defined.
module uart_frame_parser #(
    parameter int          clk_frequence = 50_000_000,
    parameter int          baud_rate     = 9600,
    parameter logic [7:0]  HEADER        = 8'hA5,
    parameter int          MAX_LEN       = 16,
    parameter int          TIMEOUT_BYTES = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   in_data,
    input  logic                         in_flag,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
    output logic [7:0]                   rd_data,
    output logic                         frame_valid,
    output logic [7:0]                   frame_cmd,
    output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
    output logic                         frame_err,
    output logic [1:0]                   err_code,
    output logic                         busy
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_LEN, ST_PAYLOAD, ST_CSUM} state_t;

    state_t          state_r, state_nx_s;
    logic [7:0]      len_r, len_nx_s;
    logic [7:0]      sum_r, sum_nx_s;
    logic [AW-1:0]   idx_r, idx_nx_s;
    logic            frame_valid_r, valid_nx_s;
    logic            frame_err_r, err_nx_s;
    logic [1:0]      err_code_r, code_nx_s;
    logic [7:0]      frame_cmd_r, fcmd_nx_s;
    logic [7:0]      cmd_r, cmd_nx_s;
    logic [LW-1:0]   frame_len_r, flen_nx_s;
    logic [7:0]      rd_data_r;
    logic            busy_r;
    logic            wr_en_s;
    logic            tmo_hit_s;
    logic [7:0]      buf_r [MAX_LEN];

`ifdef FRAME_TIMEOUT_EN
    localparam int TMO_LIMIT = (clk_frequence / baud_rate) * 10 * TIMEOUT_BYTES;
    localparam int CW        = $clog2(TMO_LIMIT) + 1;
    logic [CW-1:0] tmo_cnt_r;

    // Gap counter: runs mid-frame, restarts on every received byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ST_IDLE || in_flag) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
        end
    end

    // Fires on the edge where the counter would reach the limit.
    assign tmo_hit_s = (state_r != ST_IDLE) && (tmo_cnt_r == CW'(TMO_LIMIT - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state, field capture and result decode.
    always_comb begin
        state_nx_s = state_r;
        len_nx_s   = len_r;
        sum_nx_s   = sum_r;
        idx_nx_s   = idx_r;
        cmd_nx_s   = cmd_r;
        valid_nx_s = 1'b0;
        err_nx_s   = 1'b0;
        code_nx_s  = err_code_r;
        fcmd_nx_s  = frame_cmd_r;
        flen_nx_s  = frame_len_r;
        wr_en_s    = 1'b0;
        if (in_flag) begin
            case (state_r)
                ST_IDLE: begin
                    if (in_data == HEADER) begin
                        state_nx_s = ST_CMD;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    cmd_nx_s   = in_data;
                    sum_nx_s   = in_data;
                    state_nx_s = ST_LEN;
                end
                ST_LEN: begin
                    len_nx_s = in_data;
                    sum_nx_s = sum_r + in_data;
                    if (in_data > MAX_LEN_B) begin
                        err_nx_s   = 1'b1;
                        code_nx_s  = 2'd1;
                        state_nx_s = ST_IDLE;
                    end else if (in_data == 8'd0) begin
                        state_nx_s = ST_CSUM;
                    end else begin
                        idx_nx_s   = '0;
                        state_nx_s = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    wr_en_s  = 1'b1;
                    sum_nx_s = sum_r + in_data;
                    idx_nx_s = idx_r + AW'(1);
                    if (8'(idx_r) == len_r - 8'd1) begin
                        state_nx_s = ST_CSUM;
                    end else begin
                        state_nx_s = ST_PAYLOAD;
                    end
                end
                ST_CSUM: begin
                    if (in_data == sum_r) begin
                        valid_nx_s = 1'b1;
                        fcmd_nx_s  = cmd_r;
                        flen_nx_s  = LW'(len_r);
                    end else begin
                        err_nx_s  = 1'b1;
                        code_nx_s = 2'd2;
                    end
                    state_nx_s = ST_IDLE;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end else if (tmo_hit_s) begin
            err_nx_s   = 1'b1;
            code_nx_s  = 2'd3;
            state_nx_s = ST_IDLE;
        end else begin
            state_nx_s = state_r;
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            len_r         <= 8'd0;
            sum_r         <= 8'd0;
            idx_r         <= '0;
            cmd_r         <= 8'd0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            err_code_r    <= 2'd0;
            frame_cmd_r   <= 8'd0;
            frame_len_r   <= '0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            len_r         <= len_nx_s;
            sum_r         <= sum_nx_s;
            idx_r         <= idx_nx_s;
            cmd_r         <= cmd_nx_s;
            frame_valid_r <= valid_nx_s;
            frame_err_r   <= err_nx_s;
            err_code_r    <= code_nx_s;
            frame_cmd_r   <= fcmd_nx_s;
            frame_len_r   <= flen_nx_s;
            busy_r        <= (state_nx_s != ST_IDLE);
        end
    end

    // Payload storage, deliberately unreset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_r[idx_r] <= in_data;
        end
    end

    // Registered buffer read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= 8'd0;
        end else begin
            rd_data_r <= buf_r[rd_addr];
        end
    end

    assign rd_data     = rd_data_r;
    assign frame_valid = frame_valid_r;
    assign frame_err   = frame_err_r;
    assign err_code    = err_code_r;
    assign frame_cmd   = frame_cmd_r;
    assign frame_len   = frame_len_r;
    assign busy        = busy_r;
endmodule
